// File: rtl/alu_core.sv
// alu_core -- single-cycle registered ALU.
//
// Every rising clock edge captures the result of the operation chosen by sel
// on operands A and B. There is no handshake: one result per cycle, always
// valid one cycle after its inputs are presented.
//
// Ports
//   clock    : single clock, all state changes on its rising edge
//   reset_n  : synchronous active-low reset, clears out and carry
//   A, B     : unsigned WIDTH-bit operands
//   sel      : 4-bit operation select (0..15, see case table below)
//   out      : registered WIDTH-bit result, truncated to the low WIDTH bits
//   carry    : registered carry-out of A+B, produced for every sel value
module alu_core #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    // Widened sum: its top bit is the carry flag whatever sel is, so the
    // adder feeds both the sel=0 result and the carry register.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] res;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = A - B;              // wraps modulo 2^WIDTH
    assign prod = A * B;              // low WIDTH bits of the product
    // Division by zero saturates to all ones instead of being undefined.
    assign quot = (B == ZERO) ? ALL_ONES : (A / B);

    always_comb begin
        res = ZERO;
        unique case (sel)
            4'd0:  res = sum[WIDTH-1:0];
            4'd1:  res = diff;
            4'd2:  res = prod;
            4'd3:  res = quot;
            4'd4:  res = {A[WIDTH-2:0], 1'b0};
            4'd5:  res = {1'b0, A[WIDTH-1:1]};
            4'd6:  res = {A[WIDTH-2:0], A[WIDTH-1]};
            4'd7:  res = {A[0], A[WIDTH-1:1]};
            4'd8:  res = A & B;
            4'd9:  res = A | B;
            4'd10: res = A ^ B;
            4'd11: res = ~(A | B);
            4'd12: res = ~(A & B);
            4'd13: res = ~(A ^ B);
            4'd14: res = {{(WIDTH-1){1'b0}}, (A > B)};
            4'd15: res = {{(WIDTH-1){1'b0}}, (A == B)};
            default: res = ZERO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out   <= ZERO;
            carry <= 1'b0;
        end else begin
            out   <= res;
            carry <= sum[WIDTH];
        end
    end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    localparam int W = 5;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [W-1:0] A, B;
    logic [3:0]   sel;
    logic [W-1:0] out;
    logic         carry;

    alu_core #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .sel     (sel),
        .out     (out),
        .carry   (carry)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    eo;
        int    ec;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference behaviour in plain integer arithmetic.
    function automatic void model(input int a, input int b, input int s,
                                  output int o, output int c);
        c = ((a + b) >= 32) ? 1 : 0;
        case (s)
            0:  o = (a + b) % 32;
            1:  o = (a - b + 32) % 32;
            2:  o = (a * b) % 32;
            3:  o = (b == 0) ? 31 : a / b;
            4:  o = (a * 2) % 32;
            5:  o = a / 2;
            6:  o = ((a * 2) % 32) + (a / 16);
            7:  o = (a / 2) + ((a % 2) * 16);
            8:  o = a & b;
            9:  o = a | b;
            10: o = a ^ b;
            11: o = 31 & ~(a | b);
            12: o = 31 & ~(a & b);
            13: o = 31 & ~(a ^ b);
            14: o = (a > b) ? 1 : 0;
            default: o = (a == b) ? 1 : 0;
        endcase
    endfunction

    // Compare whatever the DUT registered at the last rising edge.
    task automatic check_pending();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (int'(out) === e.eo) else begin
                errors++;
                $error("FAIL %s out: got %0d want %0d", e.tag, out, e.eo);
            end
            checks++;
            assert (int'(carry) === e.ec) else begin
                errors++;
                $error("FAIL %s carry: got %0d want %0d", e.tag, carry, e.ec);
            end
        end
    endtask

    // On a falling edge: check the previous result, then present the next
    // vector. With glitch set, wrong values are shown first and replaced
    // before the rising edge, so only the final values may matter.
    task automatic drive(input logic rn, input int a, input int b, input int s,
                         input int eo, input int ec, input string tag,
                         input bit glitch = 1'b0);
        exp_t e;
        @(negedge clock);
        check_pending();
        reset_n = rn;
        if (glitch) begin
            A   = W'(~a);
            B   = W'(a);
            sel = 4'(s + 3);
            #2;
        end
        A   = W'(a);
        B   = W'(b);
        sel = 4'(s);
        e.eo = eo; e.ec = ec; e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int eo, ec;
        reset_n = 1'b0;
        A = '0; B = '0; sel = '0;

        drive(0, 31, 31, 0,  0, 0, "reset");
        drive(1, 31,  1, 0,  0, 1, "add_ovf");
        drive(1, 10,  5, 0, 15, 0, "add");
        drive(1,  3,  5, 1, 30, 0, "sub_wrap");
        drive(1,  7,  5, 2,  3, 0, "mul_wrap");
        drive(1, 13,  4, 3,  3, 0, "div");
        drive(1, 13,  0, 3, 31, 0, "div_zero");
        drive(1, 17,  0, 4,  2, 0, "shl");
        drive(1, 17,  0, 5,  8, 0, "shr");
        drive(1, 17,  0, 6,  3, 0, "rol");
        drive(1, 17,  0, 7, 24, 0, "ror");
        drive(1, 20, 20, 8, 20, 1, "and_carry");
        drive(1,  6,  6, 15, 1, 0, "eq_glitch", 1'b1);
        // Reset in mid-stream drops the pending result; the next edge loads
        // fresh inputs.
        drive(1, 30,  9, 14, 1, 1, "pre_rst");
        drive(0, 31,  1, 0,  0, 0, "mid_rst");
        drive(1, 31,  1, 0,  0, 1, "post_rst");

        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 32; a++)
                for (int b = 0; b < 32; b++) begin
                    model(a, b, s, eo, ec);
                    drive(1, a, b, s, eo, ec,
                          $sformatf("sweep s%0d a%0d b%0d", s, a, b));
                end

        @(negedge clock);
        check_pending();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
